// File: rtl/des_pkg.sv
// Shared DES tables, types and permutation helpers.
// IP/FP helpers are used by des_round_engine when DES_PERM_EN is defined.
package des_pkg;

    localparam int NUM_DES_ROUNDS = 16;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} des_round_state_t;
    typedef logic [31:0] half_blk_t;
    typedef logic [47:0] subkey_t;

    // Tables hold 1-based DES bit numbers; bit 1 is the vector MSB.
    localparam int E_TABLE [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int IP_TABLE [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int FP_TABLE [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    // Each box is flattened as row*16+col.
    localparam logic [3:0] S_BOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++)
            y[6'(63 - i)] = x[6'(64 - IP_TABLE[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++)
            y[6'(63 - i)] = x[6'(64 - FP_TABLE[i])];
        return y;
    endfunction

endpackage

// File: rtl/des_round_engine_if.sv
// Block-in / block-out valid-ready bundle of the DES round engine.
// master drives blocks in and takes results; slave is the engine.
interface des_round_engine_if;

    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_block;
    logic        decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_block;

    modport master (
        output in_valid, in_block, decrypt, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, decrypt, out_ready,
        output in_ready, out_valid, out_block
    );

endinterface

// File: rtl/des_f_func.sv
// Combinational DES round function f(R,K) = P(S(E(R) ^ K)).
// Pure wiring plus the eight s-box lookups.
module des_f_func
    import des_pkg::*;
(
    input  half_blk_t r,
    input  subkey_t   k,
    output half_blk_t f
);

    subkey_t   e_r;
    subkey_t   x;
    half_blk_t s_out;

    for (genvar j = 0; j < 48; j++) begin : g_e
        assign e_r[47-j] = r[32-E_TABLE[j]];
    end

    assign x = e_r ^ k;

    des_s_box #(.BOX(0)) s_box1 (.b(x[47:42]), .s(s_out[31:28]));
    des_s_box #(.BOX(1)) s_box2 (.b(x[41:36]), .s(s_out[27:24]));
    des_s_box #(.BOX(2)) s_box3 (.b(x[35:30]), .s(s_out[23:20]));
    des_s_box #(.BOX(3)) s_box4 (.b(x[29:24]), .s(s_out[19:16]));
    des_s_box #(.BOX(4)) s_box5 (.b(x[23:18]), .s(s_out[15:12]));
    des_s_box #(.BOX(5)) s_box6 (.b(x[17:12]), .s(s_out[11:8]));
    des_s_box #(.BOX(6)) s_box7 (.b(x[11:6]),  .s(s_out[7:4]));
    des_s_box #(.BOX(7)) s_box8 (.b(x[5:0]),   .s(s_out[3:0]));

    for (genvar j = 0; j < 32; j++) begin : g_p
        assign f[31-j] = s_out[32-P_TABLE[j]];
    end

endmodule

// File: rtl/des_s_box.sv
// One DES s-box: 6-bit group in, 4-bit value out.
// Row is the outer bit pair {b5,b0}, column the inner nibble.
module des_s_box
    import des_pkg::*;
#(
    parameter int BOX = 0
) (
    input  logic [5:0] b,
    output logic [3:0] s
);

    assign s = S_BOX[BOX][{b[5], b[0], b[4:1]}];

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core, one round per clock.
// Define DES_PERM_EN to wrap the rounds in IP/FP (full DES).
module des_round_engine
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_DES_ROUNDS
) (
    input  logic                clk,
    input  logic                rst,
    des_round_engine_if.slave   bus,
    output logic [3:0]          key_idx,
    input  subkey_t             subkey,
    output logic                busy
);

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

    des_round_state_t state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic             dec_q, dec_d;
    half_blk_t        l_q, l_d;
    half_blk_t        r_q, r_d;
    half_blk_t        f_out;
    logic [63:0]      ld_blk;
    logic [63:0]      res_blk;

    des_f_func u_f (
        .r (r_q),
        .k (subkey),
        .f (f_out)
    );

`ifdef DES_PERM_EN
    assign ld_blk  = ip_perm(bus.in_block);
    assign res_blk = fp_perm({r_q, l_q});
`else
    assign ld_blk  = bus.in_block;
    assign res_blk = {r_q, l_q};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            dec_q   <= 1'b0;
            l_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            dec_q   <= dec_d;
            l_q     <= l_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        dec_d   = dec_q;
        l_d     = l_q;
        r_d     = r_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = ROUND;
                    l_d     = ld_blk[63:32];
                    r_d     = ld_blk[31:0];
                    dec_d   = bus.decrypt;
                    rnd_d   = '0;
                end
            end
            ROUND: begin
                l_d   = r_q;
                r_d   = l_q ^ f_out;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LAST)
                    state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decrypt walks the subkeys from the far end.
    assign key_idx = (state_q != ROUND) ? 4'd0 :
                     dec_q ? (LAST - rnd_q) : rnd_q;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_block = (state_q == DONE) ? res_blk : '0;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine with a reference key schedule.
// Expected blocks are mapped through IP when DES_PERM_EN is not defined.
module tb_des_round_engine;

    localparam int NR = 16;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28,
        15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56,
        34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2,
                               1, 2, 2, 2, 2, 2, 2, 1};

    localparam int IPT [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    typedef struct {
        logic [63:0] key;
        logic [63:0] blk;
        logic        dec;
        logic [63:0] exp;
        int          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_idx;
    logic [47:0] subkey;
    logic        busy;
    logic [47:0] ks [16];

    int n_cmp = 0;
    int n_err = 0;

    vec_t vt [4];

    des_round_engine_if bus ();

    des_round_engine dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .key_idx (key_idx),
        .subkey  (subkey),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    assign subkey = ks[key_idx];

    function automatic logic [63:0] ip64(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++)
            y[6'(63 - i)] = x[6'(64 - IPT[i])];
        return y;
    endfunction

    // Without IP/FP in the engine, the caller feeds IP(P) and gets IP(C).
    function automatic logic [63:0] xf(input logic [63:0] x);
`ifdef DES_PERM_EN
        return x;
`else
        return ip64(x);
`endif
    endfunction

    task automatic ks_load(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        cd = '0;
        for (int i = 0; i < 56; i++)
            cd[6'(55 - i)] = key[6'(64 - PC1[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SH[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            k = '0;
            for (int i = 0; i < 48; i++)
                k[6'(47 - i)] = cd[6'(56 - PC2[i])];
            ks[r] = k;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input vec_t v, input string nm);
        int n;
        ks_load(v.key);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        chk({nm, " ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_block = v.blk;
        bus.decrypt  = v.dec;
        step();
        bus.in_valid = 1'b0;
        bus.decrypt  = ~v.dec;
        for (int r = 0; r < NR; r++) begin
            chk({nm, " kidx"}, 64'(key_idx),
                v.dec ? 64'(NR - 1 - r) : 64'(r));
            chk({nm, " ovld/busy"}, 64'({bus.out_valid, busy}), 64'd1);
            bus.in_valid = (r == 5);
            bus.in_block = ~v.blk;
            step();
        end
        bus.in_valid = 1'b0;
        chk({nm, " out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({nm, " out_block"}, bus.out_block, v.exp);
        for (int h = 0; h < v.hold; h++) begin
            bus.in_valid = 1'b1;
            step();
            chk({nm, " stall vld/rdy"},
                64'({bus.out_valid, bus.in_ready}), 64'd2);
            chk({nm, " stall blk"}, bus.out_block, v.exp);
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk({nm, " handoff"},
            64'({bus.in_ready, bus.out_valid, busy}), 64'd4);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vt[0] = '{64'h133457799BBCDFF1, xf(64'h0123456789ABCDEF),
                  1'b0, xf(64'h85E813540F0AB405), 20};
        vt[1] = '{64'h133457799BBCDFF1, xf(64'h85E813540F0AB405),
                  1'b1, xf(64'h0123456789ABCDEF), 0};
        vt[2] = '{64'h0E329232EA6D0D73, xf(64'h8787878787878787),
                  1'b0, xf(64'h0000000000000000), 1};
        vt[3] = '{64'h0E329232EA6D0D73, xf(64'h0000000000000000),
                  1'b1, xf(64'h8787878787878787), 0};

        ks_load(64'h133457799BBCDFF1);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.decrypt   = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst out_block", bus.out_block, 64'd0);
        chk("rst key_idx", 64'(key_idx), 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++)
            run_block(vt[i], $sformatf("vec%0d", i));

        // Reset in the middle of a block.
        ks_load(vt[0].key);
        bus.in_valid = 1'b1;
        bus.in_block = vt[0].blk;
        bus.decrypt  = 1'b0;
        step();
        bus.in_valid = 1'b0;
        for (int r = 0; r < 7; r++) step();
        chk("mid kidx", 64'(key_idx), 64'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid rst state",
            64'({bus.in_ready, bus.out_valid, busy}), 64'd4);
        chk("mid rst kidx", 64'(key_idx), 64'd0);
        begin
            int seen;
            seen = 0;
            bus.out_ready = 1'b1;
            for (int c = 0; c < 30; c++) begin
                step();
                if (bus.out_valid) seen++;
            end
            bus.out_ready = 1'b0;
            chk("no spurious out", 64'(seen), 64'd0);
        end

        // Reset wins over a simultaneous in_valid.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst+valid state",
            64'({bus.in_ready, bus.out_valid, busy}), 64'd4);
        step();
        chk("rst+valid idle", 64'(busy), 64'd0);

        run_block(vt[0], "again");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, got %0d errors", n_err);
        $fatal(1, "watchdog");
    end

endmodule
